// File: rtl/fsmc_mux_slave.sv
// Slave for the MCU multiplexed address/data bus (NADV/NWE/NOE/AD).
// Synchronises the MCU strobes and AD into clk, decodes a register window
// and issues single-cycle write/read requests to an external register bank.
// Read data is returned on AD with controlled turnaround. Out-of-range
// accesses and stalled address phases raise a one-cycle bus_err.
module fsmc_mux_slave #(
  parameter int AD_WIDTH = 18,
  parameter logic [AD_WIDTH-1:0] ADDR_BASE = AD_WIDTH'('h100),
  parameter int NUM_REGS = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT = 64,
  parameter logic [AD_WIDTH-1:0] READ_DEFAULT = '0,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                NADV,
  input  logic                NWE,
  input  logic                NOE,
  inout  wire  [AD_WIDTH-1:0] AD,
  output logic                wr_en,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [AD_WIDTH-1:0] wr_data,
  output logic                rd_en,
  output logic [IDX_W-1:0]    rd_addr,
  input  logic [AD_WIDTH-1:0] rd_data,
  output logic                cs,
  output logic                bus_err
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_WRITE, S_RD_REQ, S_RD_WAIT, S_RD_DRIVE
  } state_t;

  // synchroniser chains; index 0 is the first stage
  logic [SYNC_STAGES-1:0] nadv_sync_q, nadv_sync_d;
  logic [SYNC_STAGES-1:0] nwe_sync_q, nwe_sync_d;
  logic [SYNC_STAGES-1:0] noe_sync_q, noe_sync_d;
  logic [SYNC_STAGES-1:0][AD_WIDTH-1:0] ad_sync_q, ad_sync_d;
  logic nadv_dly_q, nwe_dly_q, noe_dly_q;
  logic nadv_dly_d, nwe_dly_d, noe_dly_d;

  state_t               state_q, state_d;
  logic                 in_range_q, in_range_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 cs_q, cs_d;
  logic                 wr_en_q, wr_en_d;
  logic [IDX_W-1:0]     wr_addr_q, wr_addr_d;
  logic [AD_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                 rd_en_q, rd_en_d;
  logic [IDX_W-1:0]     rd_addr_q, rd_addr_d;
  logic [AD_WIDTH-1:0]  rbuf_q, rbuf_d;
  logic                 bus_err_q, bus_err_d;
  logic                 ad_oe_q, ad_oe_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [LAT_W-1:0]     lat_q, lat_d;

  logic                nadv_s, nwe_s, noe_s;
  logic [AD_WIDTH-1:0] ad_s;
  logic                nadv_fall, nadv_rise, nwe_fall, nwe_rise, noe_fall;
  logic [AD_WIDTH:0]   addr_ext, win_lo, win_hi;
  logic                in_range_c;
  logic [IDX_W-1:0]    idx_c;

  // shift strobes and AD through equal-depth chains so AD stays aligned
  always_comb begin
    nadv_sync_d = {nadv_sync_q[SYNC_STAGES-2:0], NADV};
    nwe_sync_d  = {nwe_sync_q[SYNC_STAGES-2:0], NWE};
    noe_sync_d  = {noe_sync_q[SYNC_STAGES-2:0], NOE};
    ad_sync_d   = {ad_sync_q[SYNC_STAGES-2:0], AD};
    nadv_dly_d  = nadv_sync_q[SYNC_STAGES-1];
    nwe_dly_d   = nwe_sync_q[SYNC_STAGES-1];
    noe_dly_d   = noe_sync_q[SYNC_STAGES-1];
  end

  assign nadv_s    = nadv_sync_q[SYNC_STAGES-1];
  assign nwe_s     = nwe_sync_q[SYNC_STAGES-1];
  assign noe_s     = noe_sync_q[SYNC_STAGES-1];
  assign ad_s      = ad_sync_q[SYNC_STAGES-1];
  assign nadv_fall = nadv_dly_q & ~nadv_s;
  assign nadv_rise = ~nadv_dly_q & nadv_s;
  assign nwe_fall  = nwe_dly_q & ~nwe_s;
  assign nwe_rise  = ~nwe_dly_q & nwe_s;
  assign noe_fall  = noe_dly_q & ~noe_s;

  // window decode done one bit wider so BASE+NUM_REGS cannot wrap
  assign addr_ext   = {1'b0, ad_s};
  assign win_lo     = {1'b0, ADDR_BASE};
  assign win_hi     = win_lo + (AD_WIDTH+1)'(NUM_REGS);
  assign in_range_c = (addr_ext >= win_lo) && (addr_ext < win_hi);
  assign idx_c      = IDX_W'(ad_s - ADDR_BASE);

  // transaction FSM: next state and registered request/response outputs
  always_comb begin
    state_d    = state_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    cs_d       = cs_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rbuf_d     = rbuf_q;
    bus_err_d  = 1'b0;
    ad_oe_d    = 1'b0;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    case (state_q)
      S_IDLE: if (nadv_fall) state_d = S_ADDR;
      S_ADDR: if (nadv_rise) begin
        state_d    = S_WAIT;
        in_range_d = in_range_c;
        idx_d      = idx_c;
        cs_d       = in_range_c;
        cnt_d      = '0;
      end
      S_WAIT: begin
        if (nwe_fall) state_d = S_WRITE;           // write wins a tie
        else if (noe_fall) state_d = S_RD_REQ;
        else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end else cnt_d = cnt_q + TO_W'(1);
      end
      S_WRITE: if (nwe_rise) begin                 // data sampled only at NWE rise
        state_d   = S_IDLE;
        wr_data_d = ad_s;
        if (in_range_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
        end else bus_err_d = 1'b1;
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        lat_d   = '0;
        if (in_range_q) begin
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q;
        end else begin
          rbuf_d    = READ_DEFAULT;
          bus_err_d = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LATENCY)) begin
          if (in_range_q) rbuf_d = rd_data;
          state_d = S_RD_DRIVE;
          ad_oe_d = ~noe_s;
        end else lat_d = lat_q + LAT_W'(1);
      end
      S_RD_DRIVE: begin
        if (noe_s) state_d = S_IDLE;               // NOE released (or never held)
        else ad_oe_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // a new address phase aborts whatever was in flight, silently
    if (state_q != S_IDLE && nadv_fall) begin
      state_d   = S_ADDR;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      bus_err_d = 1'b0;
      ad_oe_d   = 1'b0;
    end
    if (state_d == S_IDLE || state_d == S_ADDR) cs_d = 1'b0;
  end

  // all state; strobes reset to inactive-high, everything else to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nadv_sync_q <= '1;
      nwe_sync_q  <= '1;
      noe_sync_q  <= '1;
      ad_sync_q   <= '0;
      nadv_dly_q  <= 1'b1;
      nwe_dly_q   <= 1'b1;
      noe_dly_q   <= 1'b1;
      state_q     <= S_IDLE;
      in_range_q  <= 1'b0;
      idx_q       <= '0;
      cs_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rbuf_q      <= '0;
      bus_err_q   <= 1'b0;
      ad_oe_q     <= 1'b0;
      cnt_q       <= '0;
      lat_q       <= '0;
    end else begin
      nadv_sync_q <= nadv_sync_d;
      nwe_sync_q  <= nwe_sync_d;
      noe_sync_q  <= noe_sync_d;
      ad_sync_q   <= ad_sync_d;
      nadv_dly_q  <= nadv_dly_d;
      nwe_dly_q   <= nwe_dly_d;
      noe_dly_q   <= noe_dly_d;
      state_q     <= state_d;
      in_range_q  <= in_range_d;
      idx_q       <= idx_d;
      cs_q        <= cs_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rbuf_q      <= rbuf_d;
      bus_err_q   <= bus_err_d;
      ad_oe_q     <= ad_oe_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
    end
  end

  // release AD in the same cycle the synchronised NOE goes high
  assign AD      = (ad_oe_q && !noe_s) ? rbuf_q : {AD_WIDTH{1'bz}};
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign cs      = cs_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_fsmc_mux_slave.sv
// Directed bench for fsmc_mux_slave. Two instances share the MCU strobes:
// u_dut at default parameters and u_dut2 with a narrow bus, a single
// register, deeper synchroniser and longer read latency. AD nets carry
// pull-ups so a released bus reads as all ones.
module tb_fsmc_mux_slave;
  localparam int W  = 18;
  localparam int W2 = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic NADV = 1'b1, NWE = 1'b1, NOE = 1'b1;
  logic tb_drv = 1'b0;
  logic [W-1:0] tb_ad = '0;
  wire  [W-1:0]  AD;
  wire  [W2-1:0] AD2;

  assign AD  = tb_drv ? tb_ad : {W{1'bz}};
  assign AD2 = tb_drv ? tb_ad[W2-1:0] : {W2{1'bz}};
  for (genvar i = 0; i < W; i++) begin : g_pu1
    pullup (AD[i]);
  end
  for (genvar i = 0; i < W2; i++) begin : g_pu2
    pullup (AD2[i]);
  end

  logic          wr_en, rd_en, cs, bus_err;
  logic [2:0]    wr_addr, rd_addr;
  logic [W-1:0]  wr_data, rd_data;
  logic          wr_en2, rd_en2, cs2, bus_err2;
  logic [0:0]    wr_addr2, rd_addr2;
  logic [W2-1:0] wr_data2, rd_data2, rd_stage2;

  fsmc_mux_slave u_dut (
    .clk(clk), .reset_n(reset_n), .NADV(NADV), .NWE(NWE), .NOE(NOE), .AD(AD),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cs(cs), .bus_err(bus_err)
  );

  fsmc_mux_slave #(
    .AD_WIDTH(W2), .NUM_REGS(1), .SYNC_STAGES(3), .RD_LATENCY(2)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .NADV(NADV), .NWE(NWE), .NOE(NOE), .AD(AD2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .cs(cs2), .bus_err(bus_err2)
  );

  always #5 clk = ~clk;

  // external register banks: latency 1 for u_dut, latency 2 for u_dut2
  logic [W-1:0]  regs [8];
  logic [W2-1:0] regs2 [1];
  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    regs2[0] = '0; rd_data = '0; rd_data2 = '0; rd_stage2 = '0;
  end
  always @(posedge clk) begin
    if (wr_en)  regs[wr_addr] <= wr_data;
    if (rd_en)  rd_data <= regs[rd_addr];
    if (wr_en2) regs2[wr_addr2] <= wr_data2;
    if (rd_en2) rd_stage2 <= regs2[rd_addr2];
    rd_data2 <= rd_stage2;
  end

  // cycle counter and pulse monitor, sampled away from the active edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_n = 0, rd_n = 0, err_n = 0, wr2_n = 0, rd2_n = 0;
  int wr_cyc = 0, wr2_cyc = 0, err_cyc = 0;
  logic [2:0]    last_wr_addr = '0, last_rd_addr = '0;
  logic [W-1:0]  last_wr_data = '0;
  logic [W2-1:0] last_wr2_data = '0;
  always @(negedge clk) begin
    if (wr_en) begin wr_n++; last_wr_addr = wr_addr; last_wr_data = wr_data; wr_cyc = cyc; end
    if (rd_en) begin rd_n++; last_rd_addr = rd_addr; end
    if (bus_err) begin err_n++; err_cyc = cyc; end
    if (wr_en2) begin wr2_n++; last_wr2_data = wr_data2; wr2_cyc = cyc; end
    if (rd_en2) rd2_n++;
  end

  int total = 0, bad = 0;
  int adv_cyc = 0, nwe_rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // address phase: NADV low 5 clk, address held one clk past NADV rise
  task automatic do_addr(input logic [W-1:0] a);
    tb_ad = a; tb_drv = 1'b1; NADV = 1'b0;
    tick(5);
    NADV = 1'b1; adv_cyc = cyc;
    tick(1);
  endtask

  // data phase of a write; data held one clk past NWE rise
  task automatic do_wdata(input logic [W-1:0] d, input int nwe_len);
    tb_ad = d;
    tick(2);
    NWE = 1'b0;
    tick(nwe_len);
    NWE = 1'b1; nwe_rise_cyc = cyc;
    tick(1);
    tb_drv = 1'b0;
    tick(6);
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    chk("rst_cs", {31'd0, cs}, 0);
    chk("rst_bus_err", {31'd0, bus_err}, 0);
    chk("rst_wr_data", {14'd0, wr_data}, 0);
    chk("rst_addrs", {26'd0, wr_addr, rd_addr}, 0);
    chk("rst_ad_released", {14'd0, AD}, 32'h3FFFF);
    reset_n = 1'b1;
    tick(3);

    // in-range write 0x100 <- 0x0F0F
    do_addr(18'h100);
    tb_ad = 18'h0F0F;
    tick(2);
    NWE = 1'b0;
    tick(4);
    chk("wr_cs_high", {31'd0, cs}, 1);
    tick(9);
    NWE = 1'b1; nwe_rise_cyc = cyc;
    tick(1);
    tb_drv = 1'b0;
    tick(6);
    chk("wr_count", wr_n, 1);
    chk("wr_addr", {29'd0, last_wr_addr}, 0);
    chk("wr_data", {14'd0, last_wr_data}, 32'h0F0F);
    chk("wr_latency", wr_cyc - nwe_rise_cyc, 3);
    chk("wr_no_err", err_n, 0);
    chk("wr_cs_idle", {31'd0, cs}, 0);
    chk("p2_wr_count", wr2_n, 1);
    chk("p2_wr_data", {16'd0, last_wr2_data}, 32'h0F0F);
    chk("p2_wr_latency", wr2_cyc - nwe_rise_cyc, 4);

    // read back 0x100, NOE low 8 clk
    do_addr(18'h100);
    tb_drv = 1'b0;
    tick(2);
    NOE = 1'b0;
    tick(7);
    chk("rd_ad_valid", {14'd0, AD}, 32'h0F0F);
    tick(1);
    chk("p2_rd_ad_valid", {16'd0, AD2}, 32'h0F0F);
    NOE = 1'b1;
    chk("rd_count", rd_n, 1);
    chk("rd_addr", {29'd0, last_rd_addr}, 0);
    chk("p2_rd_count", rd2_n, 1);
    tick(1);
    chk("rd_ad_after_rise", {14'd0, AD}, 32'h0F0F);
    chk("p2_rd_ad_after_rise", {16'd0, AD2}, 32'h0F0F);
    tick(3);
    chk("rd_ad_release", {14'd0, AD}, 32'h3FFFF);
    chk("p2_rd_ad_release", {16'd0, AD2}, 32'hFFFF);
    tick(3);
    chk("rd_no_err", err_n, 0);

    // out-of-range write and read at 0x108
    do_addr(18'h108);
    tb_ad = 18'h1234;
    tick(2);
    NWE = 1'b0;
    tick(4);
    chk("oor_cs_low", {31'd0, cs}, 0);
    tick(9);
    NWE = 1'b1;
    tick(1);
    tb_drv = 1'b0;
    tick(6);
    chk("oor_no_wr", wr_n, 1);
    chk("oor_wr_err", err_n, 1);
    do_addr(18'h108);
    tb_drv = 1'b0;
    tick(2);
    NOE = 1'b0;
    tick(7);
    chk("oor_rd_default", {14'd0, AD}, 0);
    tick(1);
    NOE = 1'b1;
    tick(6);
    chk("oor_no_rd", rd_n, 1);
    chk("oor_rd_err", err_n, 2);

    // stalled address phase times out, then a normal write to 0x103
    do_addr(18'h103);
    tb_drv = 1'b0;
    tick(70);
    chk("to_err_count", err_n, 3);
    chk("to_err_cycle", err_cyc - adv_cyc, 67);
    chk("to_no_wr", wr_n, 1);
    do_addr(18'h103);
    do_wdata(18'h0333, 6);
    chk("to_wr_count", wr_n, 2);
    chk("to_wr_addr", {29'd0, last_wr_addr}, 3);
    chk("to_wr_data", {14'd0, last_wr_data}, 32'h0333);

    // abort a write by a new address phase while NWE is still low
    do_addr(18'h101);
    tb_ad = 18'h0AAA;
    tick(2);
    NWE = 1'b0;
    tick(4);
    tb_ad = 18'h102; NADV = 1'b0;
    tick(4);
    NWE = 1'b1;
    tick(2);
    NADV = 1'b1;
    tick(1);
    chk("abort_no_wr", wr_n, 2);
    do_wdata(18'h2222, 5);
    chk("abort_wr_count", wr_n, 3);
    chk("abort_wr_addr", {29'd0, last_wr_addr}, 2);
    chk("abort_wr_data", {14'd0, last_wr_data}, 32'h2222);
    chk("abort_no_err", err_n, 3);

    // reset while driving read data
    do_addr(18'h100);
    tb_drv = 1'b0;
    tick(2);
    NOE = 1'b0;
    tick(7);
    chk("rst_mid_ad_driven", {14'd0, AD}, 32'h0F0F);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ad_release", {14'd0, AD}, 32'h3FFFF);
    chk("rst_mid_outs", {28'd0, wr_en, rd_en, cs, bus_err}, 0);
    chk("rst_mid_wr_data", {14'd0, wr_data}, 0);
    tick(2);
    NOE = 1'b1;
    reset_n = 1'b1;
    tick(4);
    chk("rst_mid_rd_count", rd_n, 2);
    chk("rst_mid_err", err_n, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsmc_mux_slave.md
Name: fsmc_mux_slave

Overview:
- Parametrised slave for the MCU multiplexed address/data bus (NADV/NWE/NOE/AD), successor to the fixed 18-bit single-register test slave.
- Synchronises the asynchronous MCU strobes into clk and latches the address from AD.
- Decodes the address against a configurable register window and issues single-cycle write and read requests to an external register bank.
- Drives read data back onto AD with controlled turnaround, plus address-range checking and a stall timeout.

Parameters:
- AD_WIDTH, 18, width of the multiplexed AD bus, address and data.
- ADDR_BASE, 18'h100, first bus address of the register window.
- NUM_REGS, 8, number of registers in the window (≥1); IDX_W = max(1, $clog2(NUM_REGS)).
- SYNC_STAGES, 2, synchroniser depth for NADV/NWE/NOE and AD (≥2).
- RD_LATENCY, 1, clk cycles from rd_en to rd_data valid (≥1).
- TIMEOUT, 64, max cycles waiting for NWE/NOE after the address phase.
- READ_DEFAULT, 0, value driven for out-of-range reads (truncated to AD_WIDTH).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- NADV  in  1  address valid, active low, asynchronous to clk
- NWE  in  1  write strobe, active low, asynchronous
- NOE  in  1  read strobe, active low, asynchronous
- AD  inout  AD_WIDTH  multiplexed address/data
- wr_en  out  1  one-cycle write request
- wr_addr  out  IDX_W  register index for write
- wr_data  out  AD_WIDTH  write data
- rd_en  out  1  one-cycle read request
- rd_addr  out  IDX_W  register index for read
- rd_data  in  AD_WIDTH  read data, valid RD_LATENCY cycles after rd_en
- cs  out  1  high while a transaction targets the window
- bus_err  out  1  one-cycle pulse on out-of-range access or timeout

Behaviour:
- Reset (reset_n low, asynchronous): FSM to IDLE; all synchroniser flops to 1 for strobes and 0 for AD; wr_en, rd_en, cs, bus_err = 0; wr_addr, rd_addr, wr_data, read buffer = 0; AD released (Z). Reset mid-transaction aborts with no wr_en or rd_en.
- Synchronisation:
  - NADV, NWE and NOE pass through SYNC_STAGES flops.
  - AD passes through an identically deep pipeline, so sampled AD is aligned with the synchronised strobes.
  - Edges are detected from the last stage against a one-cycle delayed copy.
- FSM states: IDLE, ADDR, WAIT, WRITE, RD_REQ, RD_WAIT, RD_DRIVE.
- IDLE → ADDR on NADV fall.
- ADDR → WAIT on NADV rise.
  - Latch addr = aligned AD.
  - in_range = (addr ≥ ADDR_BASE) && (addr < ADDR_BASE+NUM_REGS); idx = addr − ADDR_BASE, low IDX_W bits.
  - cs = in_range, held until return to IDLE.
- WAIT:
  - NWE fall → WRITE.
  - NOE fall → RD_REQ.
  - Counter reaches TIMEOUT → IDLE with a bus_err pulse.
  - Simultaneous NWE and NOE fall → WRITE wins.
- WRITE → IDLE on NWE rise.
  - Capture aligned AD into wr_data.
  - If in_range: wr_addr = idx and wr_en = 1 for exactly one cycle. Else bus_err pulse, no wr_en.
  - The data phase ends on the NWE rising edge; AD is sampled at that edge, never earlier.
- RD_REQ:
  - If in_range: rd_en = 1 for one cycle, rd_addr = idx.
  - Else: read buffer = READ_DEFAULT and bus_err pulse.
  - Next state RD_WAIT.
- RD_WAIT: wait RD_LATENCY cycles; capture rd_data into the read buffer for in-range reads; → RD_DRIVE.
- RD_DRIVE:
  - ad_oe registered high; AD = read buffer.
  - On synchronised NOE rise: ad_oe = 0 the same cycle, → IDLE.
  - If NOE is already high on entry, go straight to IDLE without driving.
- AD = ad_oe ? read buffer : Z. AD is never driven in any other state.
- Timing at defaults:
  - AD is valid ≤ SYNC_STAGES+RD_LATENCY+3 = 6 clk after NOE falls.
  - AD is released ≤ SYNC_STAGES+2 = 4 clk after NOE rises.
  - The MCU must hold NOE low ≥ 7 clk and allow a turnaround of ≥ 4 clk.
- NADV fall in any non-IDLE state aborts the current transaction: no wr_en, ad_oe = 0, → ADDR. It is not an error.
- Back-to-back transactions: the next NADV fall is accepted in the cycle immediately after returning to IDLE.

Test Plan:
- Write in range: NADV low 5 clk with AD=18'h100, NWE low 13 clk with AD=18'h0F0F → exactly one wr_en with wr_addr=0 and wr_data=18'h0F0F, within SYNC_STAGES+2 clk of NWE rise; cs=1 during the transaction; bus_err never asserts.
- Read back: bench register model returns 18'h0F0F for idx 0; address 18'h100, NOE low 8 clk → rd_en once with rd_addr=0; AD reads 18'h0F0F 1 clk after NOE rise; AD returns to Z within 4 clk.
- Out of range: write 18'h1234 to address 18'h108, then read it → no wr_en, no rd_en, bus_err pulses twice, read returns READ_DEFAULT=0, cs=0.
- Timeout: address phase to 18'h103 with no strobe for 70 clk → bus_err pulse at 64 cycles, FSM in IDLE; a subsequent write to 18'h103 gives wr_addr=3.
- Abort and reset: assert NADV again mid-write with NWE still low → no wr_en and the new address is taken; pull reset_n low during RD_DRIVE → AD goes to Z immediately and all outputs are 0.
- Parameter sweep: AD_WIDTH=16, NUM_REGS=1, SYNC_STAGES=3, RD_LATENCY=2 → the write/read round trip passes, with timing scaled per the bounds above.
